dcache_tag_ctrl: RTL and testbench
==================================

Name: dcache_tag_ctrl

Overview:
- Sequences the 512x21 simple-dual-port data-cache tag RAM (read latency 1 cycle, unregistered output, separate read/write ports).
- Clears all entries after reset and on a flush command.
- Serves pipelined hit/miss lookups from the load/store unit and single-cycle fill/invalidate writes from the refill engine, with write-to-read forwarding.
- Sits between the Cortex-M1 D-side bus interface and the tag RAM instance.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INDEX_WIDTH, 9, set index width; tag RAM depth = 2**INDEX_WIDTH.
- OFFSET_WIDTH, 3, line offset width (8-byte lines).
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (=20), derived localparam; RAM word = {valid, tag} = TAG_WIDTH+1 bits.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_ready  out  1  lookup accepted when valid&ready.
- req_addr  in  ADDR_WIDTH  lookup byte address.
- resp_valid  out  1  lookup result strobe; no backpressure.
- resp_hit  out  1  valid bit set and tag match.
- resp_index  out  INDEX_WIDTH  index of the responded lookup.
- upd_valid  in  1  tag write request.
- upd_ready  out  1  write accepted when valid&ready.
- upd_inv  in  1  0 = fill ({1,tag}); 1 = invalidate (all zero).
- upd_addr  in  ADDR_WIDTH  address whose index/tag is written.
- flush_req  in  1  single-cycle pulse; invalidate every entry.
- busy  out  1  sweep in progress.
- flush_done  out  1  one-cycle pulse at sweep end.
- tag_wr_en  out  1  tag RAM write enable.
- tag_wr_addr  out  INDEX_WIDTH  tag RAM write address.
- tag_wr_data  out  TAG_WIDTH+1  tag RAM write data.
- tag_rd_addr  out  INDEX_WIDTH  tag RAM read address.
- tag_rd_data  in  TAG_WIDTH+1  tag RAM read data, valid 1 cycle after tag_rd_addr.

Behaviour:
- Reset values: state=SWEEP, sweep_cnt=0, busy=1, req_ready=0, upd_ready=0, resp_valid=0, resp_hit=0, resp_index=0, flush_done=0, tag_wr_en=0.
- The RAM wr_rst/rd_rst (active-high) are driven by the top level.
- FSM has two states, SWEEP and RUN.
- SWEEP: tag_wr_en=1, tag_wr_addr=sweep_cnt, tag_wr_data=0; sweep_cnt increments each cycle.
  - When sweep_cnt = 2**INDEX_WIDTH-1, the write occurs and the FSM moves to RUN next cycle; flush_done pulses in the first RUN cycle.
  - Full sweep = 512 write cycles.
  - req_ready=0 and upd_ready=0 throughout.
  - flush_req during SWEEP is ignored (no restart).
- RUN: req_ready=1, upd_ready=1 (combinational ~busy).
  - flush_req (sampled) moves to SWEEP next cycle and clears sweep_cnt.
  - Any lookup accepted in the flush cycle still produces its response.
  - An upd accepted in the flush cycle is written.
- Lookup pipeline:
  - Accept cycle N: tag_rd_addr = req_addr index; the req tag and index are registered.
  - Cycle N+1: resp_valid=1; resp_hit = rd_word[TAG_WIDTH] & (rd_word[TAG_WIDTH-1:0] == registered tag).
  - Throughput is 1 lookup/cycle; the pipeline does not stall.
- Update:
  - Accept cycle N: tag_wr_en=1, tag_wr_addr=index, tag_wr_data = upd_inv ? 0 : {1'b1, tag}.
  - Lookups and updates proceed in the same cycle (separate ports).
- Forwarding (RAM read-during-write returns old data):
  - If an update and a lookup to the same index are accepted in the same cycle N, the compare in N+1 uses the registered write word instead of tag_rd_data.
  - A write in cycle N is visible to a RAM read issued in N+1 without forwarding.
- When idle, tag_rd_addr holds its last value.
- Reset assertion mid-sweep or mid-lookup: all state is dropped and the full sweep restarts after release.

Decomposition:
- Package dcache_pkg: INDEX_WIDTH, OFFSET_WIDTH, TAG_WIDTH, and index/tag slice functions (shared with the data-RAM controller).
- One sub-module, dcache_tag_cmp: registered tag/index, bypass mux and hit compare.
- The FSM, sweep counter and write mux stay in the top.

Test Plan:
- Reset release -> busy=1 for exactly 512 cycles with tag_wr_addr 0..511 and tag_wr_data=0; flush_done pulses once; req_ready rises on the same cycle.
- Lookup 0x0000_1238 after sweep -> resp_valid next cycle, resp_hit=0, resp_index=0x047.
- Fill 0x0000_1238, then lookup 0x0000_123C two cycles later -> resp_hit=1.
- Lookup 0x8000_1238 (same index, different tag) -> resp_hit=0.
- Same-cycle fill and lookup of 0x0000_2000 -> resp_hit=1 via forwarding.
- Same-cycle invalidate and lookup of a filled line -> resp_hit=0.
- Fill, then flush_req, then lookup -> busy 512 cycles; lookup after flush_done -> resp_hit=0.
- A second flush_req mid-sweep -> sweep length stays 512.
- rst_n pulsed low at sweep cycle 200 -> the sweep restarts from index 0 and completes 512 writes after release.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared data-cache geometry and address slicing helpers.
// Used by the tag controller and the data-RAM controller.
package dcache_pkg;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned INDEX_WIDTH  = 9;
  localparam int unsigned OFFSET_WIDTH = 3;
  localparam int unsigned TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int unsigned WORD_WIDTH   = TAG_WIDTH + 1;
  localparam int unsigned DEPTH        = 2 ** INDEX_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [INDEX_WIDTH-1:0] index_t;
  typedef logic [TAG_WIDTH-1:0]   tag_t;

  // Tag RAM word layout: valid in the MSB, tag below it.
  typedef struct packed {
    logic valid;
    tag_t tag;
  } tag_word_t;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic index_t addr_index(input addr_t addr);
    return addr[OFFSET_WIDTH +: INDEX_WIDTH];
  endfunction

  function automatic tag_t addr_tag(input addr_t addr);
    return addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  endfunction

endpackage

// File: rtl/dcache_tag_ctrl_if.sv
// Lookup and tag-update channels between the D-side bus logic and the tag controller.
interface dcache_tag_ctrl_if;
  import dcache_pkg::*;

  logic   req_valid;
  logic   req_ready;
  addr_t  req_addr;
  logic   resp_valid;
  logic   resp_hit;
  index_t resp_index;
  logic   upd_valid;
  logic   upd_ready;
  logic   upd_inv;
  addr_t  upd_addr;

  modport master (
    output req_valid, req_addr, upd_valid, upd_inv, upd_addr,
    input  req_ready, resp_valid, resp_hit, resp_index, upd_ready
  );

  modport slave (
    input  req_valid, req_addr, upd_valid, upd_inv, upd_addr,
    output req_ready, resp_valid, resp_hit, resp_index, upd_ready
  );

endinterface

// File: rtl/dcache_tag_cmp.sv
// Second lookup stage: holds the request tag/index, bypasses a same-cycle
// write to the same set and compares against the selected tag word.
module dcache_tag_cmp
  import dcache_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      req_fire,
  input  index_t    req_index,
  input  tag_t      req_tag,
  input  logic      upd_fire,
  input  index_t    upd_index,
  input  tag_word_t upd_word,
  input  tag_word_t rd_word,
  output logic      resp_valid,
  output logic      resp_hit,
  output index_t    resp_index
);

  tag_t      tag_q;
  logic      fwd_q;
  tag_word_t fwd_word_q;
  tag_word_t cmp_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_index <= '0;
      tag_q      <= '0;
      fwd_q      <= 1'b0;
      fwd_word_q <= '0;
    end else begin
      resp_valid <= req_fire;
      if (req_fire) begin
        resp_index <= req_index;
        tag_q      <= req_tag;
        fwd_q      <= upd_fire && (upd_index == req_index);
        fwd_word_q <= upd_word;
      end
    end
  end

  // RAM returns pre-write data on a same-cycle collision, so take the written word instead.
  always_comb begin
    cmp_word = fwd_q ? fwd_word_q : rd_word;
    resp_hit = resp_valid & cmp_word.valid & (cmp_word.tag == tag_q);
  end

endmodule

// File: rtl/dcache_tag_ctrl.sv
// Data-cache tag RAM sequencer: post-reset/flush clearing sweep, pipelined
// hit/miss lookups and fill/invalidate writes from the refill engine.
module dcache_tag_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  dcache_tag_ctrl_if.slave      bus,
  input  logic                  flush_req,
  output logic                  busy,
  output logic                  flush_done,
  output logic                  tag_wr_en,
  output index_t                tag_wr_addr,
  output logic [WORD_WIDTH-1:0] tag_wr_data,
  output index_t                tag_rd_addr,
  input  logic [WORD_WIDTH-1:0] tag_rd_data,
  output logic                  tag_wr_rst_c,
  output logic                  tag_rd_rst_c
);

  state_e    state_q, state_d;
  index_t    sweep_cnt_q, sweep_cnt_d;
  logic      flush_done_d;
  index_t    rd_addr_q;
  logic      req_fire;
  logic      upd_fire;
  tag_word_t upd_word;

  assign tag_wr_rst_c = ~rst_n;
  assign tag_rd_rst_c = ~rst_n;

  assign busy          = (state_q == SWEEP);
  assign bus.req_ready = ~busy;
  assign bus.upd_ready = ~busy;
  assign req_fire      = bus.req_valid & ~busy;
  assign upd_fire      = bus.upd_valid & ~busy;

  always_comb begin
    upd_word = '0;
    if (!bus.upd_inv) begin
      upd_word.valid = 1'b1;
      upd_word.tag   = addr_tag(bus.upd_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      sweep_cnt_q <= '0;
      flush_done  <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      flush_done  <= flush_done_d;
      rd_addr_q   <= tag_rd_addr;
    end
  end

  // Next state and tag RAM write port mux: sweep owns the port while clearing.
  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    flush_done_d = 1'b0;
    tag_wr_en    = 1'b0;
    tag_wr_addr  = addr_index(bus.upd_addr);
    tag_wr_data  = upd_word;
    case (state_q)
      SWEEP: begin
        // Gated by rst_n so no write leaks out while the RAM is held in reset.
        tag_wr_en   = rst_n;
        tag_wr_addr = sweep_cnt_q;
        tag_wr_data = '0;
        sweep_cnt_d = sweep_cnt_q + index_t'(1);
        if (sweep_cnt_q == index_t'(DEPTH - 1)) begin
          state_d      = RUN;
          flush_done_d = 1'b1;
        end
      end
      RUN: begin
        tag_wr_en = bus.upd_valid;
        if (flush_req) begin
          state_d     = SWEEP;
          sweep_cnt_d = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // Read address follows the accepted lookup and holds otherwise.
  assign tag_rd_addr = req_fire ? addr_index(bus.req_addr) : rd_addr_q;

  dcache_tag_cmp u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_fire   (req_fire),
    .req_index  (addr_index(bus.req_addr)),
    .req_tag    (addr_tag(bus.req_addr)),
    .upd_fire   (upd_fire),
    .upd_index  (addr_index(bus.upd_addr)),
    .upd_word   (upd_word),
    .rd_word    (tag_word_t'(tag_rd_data)),
    .resp_valid (bus.resp_valid),
    .resp_hit   (bus.resp_hit),
    .resp_index (bus.resp_index)
  );

endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// Bench for dcache_tag_ctrl: tag RAM model, cache-content model with a
// per-cycle compare process, and directed literal expectations.
module tb_dcache_tag_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_req = 1'b0;
  logic        busy, flush_done, tag_wr_en, tag_wr_rst_c, tag_rd_rst_c;
  logic [8:0]  tag_wr_addr, tag_rd_addr;
  logic [20:0] tag_wr_data, tag_rd_data;

  int n_checks = 0;
  int n_err    = 0;

  dcache_tag_ctrl_if bus();

  always #5 clk = ~clk;

  dcache_tag_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .flush_req    (flush_req),
    .busy         (busy),
    .flush_done   (flush_done),
    .tag_wr_en    (tag_wr_en),
    .tag_wr_addr  (tag_wr_addr),
    .tag_wr_data  (tag_wr_data),
    .tag_rd_addr  (tag_rd_addr),
    .tag_rd_data  (tag_rd_data),
    .tag_wr_rst_c (tag_wr_rst_c),
    .tag_rd_rst_c (tag_rd_rst_c)
  );

  // Tag RAM: 1-cycle read, read-during-write returns the old word; starts with valid-looking garbage.
  logic [20:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = {1'b1, 20'($urandom)};
  always @(posedge clk) begin
    if (tag_wr_en) mem[tag_wr_addr] <= tag_wr_data;
    tag_rd_data <= mem[tag_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned f_idx(input logic [31:0] a);
    return (a >> 3) % 512;
  endfunction

  function automatic int unsigned f_tag(input logic [31:0] a);
    return a >> 12;
  endfunction

  // Cache-content model: which sets hold which tags, sweep cycles left, pending response.
  bit          m_valid [512];
  logic [19:0] m_tag [512];
  int          m_left = 512;
  bit          m_fd = 1'b0;
  bit          m_rv = 1'b0;
  bit          m_rh = 1'b0;
  logic [8:0]  m_ri = '0;
  logic [8:0]  m_rd_addr = '0;
  bit          e_busy, acc;
  int unsigned ui, ri;
  logic [8:0]  e_ra;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_upd_ready", 32'(bus.upd_ready), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      chk("rst_tag_wr_en", 32'(tag_wr_en), 32'd0);
      chk("rst_ram_rst", 32'({tag_wr_rst_c, tag_rd_rst_c}), 32'd3);
      m_left = 512; m_fd = 0; m_rv = 0; m_rd_addr = '0;
      for (int i = 0; i < 512; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
    end else begin
      e_busy = (m_left > 0);
      chk("busy", 32'(busy), 32'(e_busy));
      chk("req_ready", 32'(bus.req_ready), 32'(!e_busy));
      chk("upd_ready", 32'(bus.upd_ready), 32'(!e_busy));
      chk("flush_done", 32'(flush_done), 32'(m_fd));
      chk("resp_valid", 32'(bus.resp_valid), 32'(m_rv));
      chk("ram_rst", 32'({tag_wr_rst_c, tag_rd_rst_c}), 32'd0);
      if (m_rv) begin
        chk("resp_hit", 32'(bus.resp_hit), 32'(m_rh));
        chk("resp_index", 32'(bus.resp_index), 32'(m_ri));
      end
      ui = f_idx(bus.upd_addr);
      ri = f_idx(bus.req_addr);
      if (e_busy) begin
        chk("sweep_wr_en", 32'(tag_wr_en), 32'd1);
        chk("sweep_wr_addr", 32'(tag_wr_addr), 32'(512 - m_left));
        chk("sweep_wr_data", 32'(tag_wr_data), 32'd0);
      end else begin
        chk("upd_wr_en", 32'(tag_wr_en), 32'(bus.upd_valid));
        if (bus.upd_valid) begin
          chk("upd_wr_addr", 32'(tag_wr_addr), 32'(ui));
          chk("upd_wr_data", 32'(tag_wr_data),
              bus.upd_inv ? 32'd0 : 32'((1 << 20) | (f_tag(bus.upd_addr) & 32'hFFFFF)));
        end
      end
      acc  = !e_busy && bus.req_valid;
      e_ra = acc ? 9'(ri) : m_rd_addr;
      chk("tag_rd_addr", 32'(tag_rd_addr), 32'(e_ra));
      m_rd_addr = e_ra;
      // Advance to the next cycle: a same-cycle update is already visible to the lookup.
      if (!e_busy && bus.upd_valid) begin
        m_valid[ui] = !bus.upd_inv;
        m_tag[ui]   = bus.upd_inv ? 20'd0 : 20'(f_tag(bus.upd_addr));
      end
      m_rv = acc;
      if (acc) begin
        m_rh = m_valid[ri] && (m_tag[ri] == 20'(f_tag(bus.req_addr)));
        m_ri = 9'(ri);
      end
      m_fd = e_busy && (m_left == 1);
      if (e_busy) m_left--;
      else if (flush_req) begin
        m_left = 512;
        for (int i = 0; i < 512; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
      end
    end
  end

  task automatic drive(input bit rv, input logic [31:0] ra, input bit uv, input bit uinv,
                       input logic [31:0] ua, input bit fl);
    @(posedge clk); #1;
    bus.req_valid = rv; bus.req_addr = ra;
    bus.upd_valid = uv; bus.upd_inv = uinv; bus.upd_addr = ua;
    flush_req = fl;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  // Lookup (optionally with a same-cycle update) and check the response literally.
  task automatic look(input logic [31:0] a, input bit uv, input bit uinv, input bit e_hit,
                      input logic [8:0] e_idx, input string nm);
    drive(1, a, uv, uinv, a, 0);
    idle();
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({nm, "_hit"}, 32'(bus.resp_hit), 32'(e_hit));
    chk({nm, "_index"}, 32'(bus.resp_index), 32'(e_idx));
  endtask

  // Count busy cycles of a sweep whose trigger was driven in the current cycle.
  task automatic run_sweep(input int flush_at, input int rst_at, output int n);
    bit done;
    done = 0; n = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(posedge clk); #1;
      bus.req_valid = 0; bus.upd_valid = 0;
      flush_req = (n == flush_at);
      if (n == rst_at) begin
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        n = 0; rst_at = -1;
      end
      @(negedge clk);
      if (busy) n++;
      else done = 1;
    end
    if (!done) begin
      n_checks++; n_err++;
      $display("FAIL sweep_timeout busy still %0d after %0d cycles", busy, n);
    end
  endtask

  logic [31:0] tbl [6];
  int n;

  initial begin
    bus.req_valid = 0; bus.req_addr = '0;
    bus.upd_valid = 0; bus.upd_inv = 0; bus.upd_addr = '0;
    tbl[0] = 32'h0000_1238; tbl[1] = 32'h0000_5238; tbl[2] = 32'h0000_2000;
    tbl[3] = 32'h0000_2008; tbl[4] = 32'hFFFF_FFF8; tbl[5] = 32'h0000_1FF8;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("init_sweep_len", 32'(n), 32'd512);
    chk("init_flush_done", 32'(flush_done), 32'd1);
    chk("init_req_ready", 32'(bus.req_ready), 32'd1);

    look(32'h0000_1238, 0, 0, 0, 9'h047, "cold_miss");
    drive(0, 32'h0, 1, 0, 32'h0000_1238, 0);
    idle();
    look(32'h0000_123C, 0, 0, 1, 9'h047, "fill_hit");
    look(32'h8000_1238, 0, 0, 0, 9'h047, "tag_miss");
    look(32'h0000_2000, 1, 0, 1, 9'h000, "fwd_fill");
    look(32'h0000_2000, 1, 1, 0, 9'h000, "fwd_inv");
    look(32'h0000_2000, 0, 0, 0, 9'h000, "after_inv");
    drive(0, 32'h0, 1, 0, 32'hFFFF_FFF8, 0);
    look(32'hFFFF_FFF8, 0, 0, 1, 9'h1FF, "top_set_hit");

    // Mixed back-to-back traffic, checked by the model only.
    for (int i = 0; i < 48; i++)
      drive((i % 3) != 2, tbl[i % 6], ((i % 4) == 1) || ((i % 5) == 0), (i % 7) == 3,
            tbl[(i * 5) % 6], 0);
    idle();

    // Flush with a lookup and a fill in the same cycle.
    drive(0, 32'h0, 1, 0, 32'h0000_1238, 0);
    drive(1, 32'h0000_1238, 1, 0, 32'h0000_3008, 1);
    run_sweep(-1, -1, n);
    chk("flush_sweep_len", 32'(n), 32'd512);
    chk("flush_done_pulse", 32'(flush_done), 32'd1);
    look(32'h0000_1238, 0, 0, 0, 9'h047, "post_flush");
    look(32'h0000_3008, 0, 0, 0, 9'h001, "post_flush_upd");

    drive(0, 32'h0, 0, 0, 32'h0, 1);
    run_sweep(100, -1, n);
    chk("reflush_sweep_len", 32'(n), 32'd512);

    drive(0, 32'h0, 0, 0, 32'h0, 1);
    run_sweep(-1, 200, n);
    chk("rst_sweep_len", 32'(n), 32'd512);
    look(32'hFFFF_FFF8, 0, 0, 0, 9'h1FF, "post_rst");

    idle();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, errors so far %0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
